// File: rtl/ex_mem_stage_pkg.sv
// Shared definitions for the EX/MEM pipeline register: default datapath
// width and the funct3 encodings of the conditional branches.
package ex_mem_stage_pkg;

  localparam int N_DEFAULT = 32;

  typedef enum logic [2:0] {
    F3_BEQ  = 3'b000,
    F3_BNE  = 3'b001,
    F3_BLT  = 3'b100,
    F3_BGE  = 3'b101,
    F3_BLTU = 3'b110,
    F3_BGEU = 3'b111
  } br_funct3_e;

endpackage

// File: rtl/ex_mem_stage_branch_cond.sv
// Combinational branch decision from funct3 and the subtract flags.
// Carry follows the "C=1 means no borrow" convention, so BGEU is taken on C.
// The two unused funct3 codes (010/011) never take.
module branch_cond
  import ex_mem_stage_pkg::*;
(
  input  logic [2:0] funct3,
  input  logic       zflag,
  input  logic       cflag,
  input  logic       vflag,
  input  logic       sflag,
  output logic       taken
);

  // Decode funct3 into a flag test.
  always_comb begin
    taken = 1'b0;
    case (funct3)
      F3_BEQ:  taken = zflag;
      F3_BNE:  taken = ~zflag;
      F3_BLT:  taken = sflag ^ vflag;
      F3_BGE:  taken = ~(sflag ^ vflag);
      F3_BLTU: taken = ~cflag;
      F3_BGEU: taken = cflag;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register with branch resolution.
// Priority per edge: rst > flush > stall > load. Flush clears valid and the
// control bits but keeps the data fields. Branch resolution and the taken
// branch counter exist only when EX_MEM_BRANCH_RESOLVE_EN is defined;
// otherwise both outputs are tied to zero and the flags are ignored.
module ex_mem_stage
  import ex_mem_stage_pkg::*;
#(
  parameter int n = N_DEFAULT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         stall,
  input  logic         flush,
  input  logic         ex_valid,
  input  logic [n-1:0] ex_alu_out,
  input  logic         ex_zflag,
  input  logic         ex_cflag,
  input  logic         ex_vflag,
  input  logic         ex_sflag,
  input  logic [n-1:0] ex_rs2_data,
  input  logic [4:0]   ex_rd,
  input  logic         ex_reg_write,
  input  logic         ex_mem_read,
  input  logic         ex_mem_write,
  input  logic         ex_branch,
  input  logic [2:0]   ex_funct3,
  input  logic [n-1:0] ex_pc_target,
  output logic         mem_valid,
  output logic         mem_reg_write,
  output logic         mem_mem_read,
  output logic         mem_mem_write,
  output logic [n-1:0] mem_alu_out,
  output logic [n-1:0] mem_rs2_data,
  output logic [n-1:0] mem_pc_target,
  output logic [4:0]   mem_rd,
  output logic [2:0]   mem_funct3,
  output logic         mem_branch_taken,
  output logic [31:0]  taken_count
);

  // Pipeline register for valid, control and data fields.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_valid     <= 1'b0;
      mem_reg_write <= 1'b0;
      mem_mem_read  <= 1'b0;
      mem_mem_write <= 1'b0;
      mem_alu_out   <= '0;
      mem_rs2_data  <= '0;
      mem_pc_target <= '0;
      mem_rd        <= '0;
      mem_funct3    <= '0;
    end else if (flush) begin
      mem_valid     <= 1'b0;
      mem_reg_write <= 1'b0;
      mem_mem_read  <= 1'b0;
      mem_mem_write <= 1'b0;
    end else if (!stall) begin
      mem_valid     <= ex_valid;
      mem_reg_write <= ex_reg_write & ex_valid;
      mem_mem_read  <= ex_mem_read & ex_valid;
      mem_mem_write <= ex_mem_write & ex_valid;
      mem_alu_out   <= ex_alu_out;
      mem_rs2_data  <= ex_rs2_data;
      mem_pc_target <= ex_pc_target;
      mem_rd        <= ex_rd;
      mem_funct3    <= ex_funct3;
    end
  end

`ifdef EX_MEM_BRANCH_RESOLVE_EN
  logic cond_taken;
  logic load_taken;

  branch_cond u_branch_cond (
    .funct3 (ex_funct3),
    .zflag  (ex_zflag),
    .cflag  (ex_cflag),
    .vflag  (ex_vflag),
    .sflag  (ex_sflag),
    .taken  (cond_taken)
  );

  assign load_taken = ex_valid & ex_branch & cond_taken;

  // Registered branch decision and a wrapping count of taken branches.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_branch_taken <= 1'b0;
      taken_count      <= '0;
    end else if (flush) begin
      mem_branch_taken <= 1'b0;
    end else if (!stall) begin
      mem_branch_taken <= load_taken;
      if (load_taken) taken_count <= taken_count + 32'd1;
    end
  end
`else
  logic unused_branch_inputs;

  assign unused_branch_inputs = ^{ex_zflag, ex_cflag, ex_vflag, ex_sflag, ex_branch};
  assign mem_branch_taken     = 1'b0;
  assign taken_count          = '0;
`endif

endmodule

// File: doc/ex_mem_stage.md
EX_MEM_STAGE -- requirements
Module: ex_mem_stage

Interface
REQ-001 Parameter n, default 32, datapath width of all data ports.
REQ-002 Clock and reset: one clock, clk; reset rst is synchronous and active-high.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 stall  input  1  hold all registered state this cycle.
REQ-006 flush  input  1  squash the instruction entering the stage.
REQ-007 ex_valid  input  1  EX holds a real instruction.
REQ-008 ex_alu_out  input  n  ALU result.
REQ-009 ex_zflag, ex_cflag, ex_vflag, ex_sflag  input  1 each  ALU Z/C/V/S flags from the subtract operation.
REQ-010 ex_rs2_data  input  n  store data.
REQ-011 ex_rd  input  5  destination register index.
REQ-012 ex_reg_write, ex_mem_read, ex_mem_write, ex_branch  input  1 each  control bits.
REQ-013 ex_funct3  input  3  branch/load/store funct3.
REQ-014 ex_pc_target  input  n  branch target address.
REQ-015 mem_valid, mem_reg_write, mem_mem_read, mem_mem_write  output  1 each  registered copies.
REQ-016 mem_alu_out, mem_rs2_data, mem_pc_target  output  n each  registered copies.
REQ-017 mem_rd  output  5; mem_funct3  output  3; registered copies.
REQ-018 mem_branch_taken  output  1  registered branch decision.
REQ-019 taken_count  output  32  count of taken branches.

Function
REQ-020 Per rising edge, priority SHALL be rst > flush > stall > load.
REQ-021 Load: every mem_* output SHALL take its ex_* input; latency exactly 1 cycle.
REQ-022 Control outputs (mem_reg_write, mem_mem_read, mem_mem_write, mem_branch_taken) SHALL be loaded as ex_* AND ex_valid.
REQ-023 Branch condition from flags: 000 BEQ=Z; 001 BNE=!Z; 100 BLT=S!=V; 101 BGE=S==V; 110 BLTU=!C; 111 BGEU=C; 010/011 SHALL be not-taken.
REQ-024 Carry convention: C=1 means no borrow (A>=B unsigned); the block SHALL use flags unmodified.
REQ-025 mem_branch_taken SHALL load ex_valid & ex_branch & condition.
REQ-026 Flush: mem_valid and all control outputs SHALL become 0; data outputs SHALL hold their previous value.
REQ-027 Stall: all outputs and taken_count SHALL hold; ex_* SHALL be ignored.
REQ-028 Flush and stall together: flush SHALL win.
REQ-029 taken_count SHALL increment by 1 on each load cycle where the loaded mem_branch_taken is 1; flushed or stalled cycles SHALL NOT count.
REQ-030 taken_count SHALL wrap from 32'hFFFFFFFF to 0 without flag or saturation.
REQ-031 No combinational path SHALL exist from any input to any output.

Reset
REQ-032 On rst, all outputs SHALL be 0, including data outputs and taken_count.
REQ-033 rst asserted mid-stall or mid-flush SHALL take effect that same edge; the first load SHALL occur on the first edge with rst=0.

Configuration
REQ-034 Macro EX_MEM_BRANCH_RESOLVE_EN defined: REQ-023, REQ-025 and REQ-029 SHALL apply.
REQ-035 Macro EX_MEM_BRANCH_RESOLVE_EN undefined: mem_branch_taken and taken_count SHALL be constant 0 and the flag inputs unused; all other behaviour SHALL be unchanged.

Structure
REQ-036 Shared package SHALL hold funct3 branch constants (BEQ..BGEU) and the width parameter default of 32.
REQ-037 Sub-module branch_cond SHALL hold the combinational funct3/flags-to-taken decode; all registers SHALL stay in ex_mem_stage.

Verification
REQ-038 Load: ex_valid=1, ex_alu_out=32'h0000_1234, ex_rd=5, ex_reg_write=1 -> next cycle mem_alu_out=32'h1234, mem_rd=5, mem_reg_write=1, mem_valid=1.
REQ-039 Branch: funct3=100, ex_branch=1, S=1, V=0 -> mem_branch_taken=1, taken_count 0->1; same with S=1, V=1 -> taken=0, count unchanged.
REQ-040 Stall: stall=1 for 3 cycles with changing ex_* inputs -> outputs frozen at pre-stall values; the first load after stall releases captures the current ex_* inputs.
REQ-041 Flush+stall: both=1 with ex_branch taken -> mem_valid=0, mem_branch_taken=0, taken_count unchanged, mem_alu_out held.
REQ-042 Wrap: force taken_count to 32'hFFFFFFFF, one taken branch -> taken_count=0.
REQ-043 Reset: rst=1 during a taken-branch load -> all outputs 0 next cycle; ex_valid=0 with ex_mem_write=1 -> mem_mem_write=0.
